// File: rtl/rom_port_arbiter.sv
// rom_port_arbiter: shares the single-read-port code ROM between instruction fetch and data load
module rom_port_arbiter #(
    parameter int ROM_LAT    = 1,
    parameter int STARVE_MAX = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        i_req,
    input  logic [31:0] i_addr,
    output logic        i_gnt,
    output logic        i_rvalid,
    output logic [31:0] i_rdata,
    output logic        i_err,
    input  logic        d_req,
    input  logic [31:0] d_addr,
    output logic        d_gnt,
    output logic        d_rvalid,
    output logic [31:0] d_rdata,
    output logic        d_err,
    output logic [31:0] rom_addr,
    output logic        rom_cs,
    input  logic [31:0] rom_data
);
    localparam int SW = STARVE_MAX > 0 ? $clog2(STARVE_MAX + 1) : 1;
    localparam int LW = $clog2(ROM_LAT + 1);
    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;
    state_t        state;
    logic [SW-1:0] starve_cnt;
    logic [LW-1:0] wait_cnt;
    logic          owner;
    logic          force_i;
    logic          d_win;
    logic          grant;
    logic          mis;
    logic          done;
    logic          resp_d;
    logic [31:0]   g_addr;
    // Fetch overrides data priority only once it has lost STARVE_MAX arbitrations in a row
    always_comb begin
        force_i = STARVE_MAX != 0 && starve_cnt == SW'(STARVE_MAX) && i_req;
        d_win   = d_req && !force_i;
        i_gnt   = state == IDLE && !reset && i_req && !d_win;
        d_gnt   = state == IDLE && !reset && d_win;
        grant   = i_gnt || d_gnt;
        g_addr  = d_gnt ? d_addr : i_addr;
        mis     = grant && g_addr[1:0] != 2'b00;
        done    = state == WAIT && wait_cnt == '0;
        resp_d  = mis ? d_gnt : owner;
    end
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            starve_cnt <= '0;
            wait_cnt   <= '0;
            owner      <= 1'b0;
            rom_addr   <= '0;
            rom_cs     <= 1'b0;
            i_rvalid   <= 1'b0;
            i_rdata    <= '0;
            i_err      <= 1'b0;
            d_rvalid   <= 1'b0;
            d_rdata    <= '0;
            d_err      <= 1'b0;
        end else begin
            rom_cs   <= 1'b0;
            i_rvalid <= 1'b0;
            d_rvalid <= 1'b0;
            if (!i_req || i_gnt)
                starve_cnt <= '0;
            else if (d_gnt && starve_cnt != SW'(STARVE_MAX))
                starve_cnt <= starve_cnt + 1'b1;
            // Misaligned accesses answer straight from the grant, never touching the ROM
            if (mis || done) begin
                if (resp_d) begin
                    d_rvalid <= 1'b1;
                    d_rdata  <= mis ? '0 : rom_data;
                    d_err    <= mis;
                end else begin
                    i_rvalid <= 1'b1;
                    i_rdata  <= mis ? '0 : rom_data;
                    i_err    <= mis;
                end
            end
            case (state)
                IDLE: if (grant) begin
                    owner <= d_gnt;
                    if (mis) begin
                        state <= RESP;
                    end else begin
                        state    <= ISSUE;
                        rom_addr <= g_addr;
                        rom_cs   <= 1'b1;
                    end
                end
                ISSUE: begin
                    state    <= WAIT;
                    wait_cnt <= LW'(ROM_LAT - 1);
                end
                WAIT: if (done) state <= RESP; else wait_cnt <= wait_cnt - 1'b1;
                RESP: state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_rom_port_arbiter.sv
// tb_rom_port_arbiter: scoreboard bench for rom_port_arbiter with ROM_LAT=1 and ROM_LAT=3 instances
module tb_rom_port_arbiter;
    logic clk = 1'b0, reset = 1'b1;
    always #5 clk = ~clk;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;
    int n_cmp = 0, n_bad = 0;
    logic        i_req = 1'b0, d_req = 1'b0;
    logic [31:0] i_addr = '0, d_addr = '0;
    logic        i_gnt, i_rvalid, i_err, d_gnt, d_rvalid, d_err, rom_cs;
    logic [31:0] i_rdata, d_rdata, rom_addr, rom_data;
    logic        b_i_req = 1'b0, b_d_req = 1'b0;
    logic [31:0] b_i_addr = '0, b_d_addr = '0;
    logic        b_i_gnt, b_i_rvalid, b_i_err, b_d_gnt, b_d_rvalid, b_d_err, b_rom_cs;
    logic [31:0] b_i_rdata, b_d_rdata, b_rom_addr, b_rom_data;

    rom_port_arbiter #(.ROM_LAT(1), .STARVE_MAX(4)) u_a (
        .clk(clk), .reset(reset),
        .i_req(i_req), .i_addr(i_addr), .i_gnt(i_gnt), .i_rvalid(i_rvalid), .i_rdata(i_rdata), .i_err(i_err),
        .d_req(d_req), .d_addr(d_addr), .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata), .d_err(d_err),
        .rom_addr(rom_addr), .rom_cs(rom_cs), .rom_data(rom_data));

    rom_port_arbiter #(.ROM_LAT(3), .STARVE_MAX(4)) u_b (
        .clk(clk), .reset(reset),
        .i_req(b_i_req), .i_addr(b_i_addr), .i_gnt(b_i_gnt), .i_rvalid(b_i_rvalid), .i_rdata(b_i_rdata), .i_err(b_i_err),
        .d_req(b_d_req), .d_addr(b_d_addr), .d_gnt(b_d_gnt), .d_rvalid(b_d_rvalid), .d_rdata(b_d_rdata), .d_err(b_d_err),
        .rom_addr(b_rom_addr), .rom_cs(b_rom_cs), .rom_data(b_rom_data));

    function automatic logic [31:0] mem(input logic [31:0] a);
        case (a)
            32'h16C: mem = 32'h00000093;
            32'h170: mem = 32'h00000113;
            32'h18C: mem = 32'h0000A703;
            32'h198: mem = 32'h2A761663;
            32'h17C: mem = 32'h00FF07B7;
            default: mem = {a[15:0] ^ 16'h5A5A, ~a[15:0]};
        endcase
    endfunction

    // ROM models drive valid data only in the cycle ROM_LAT cycles after the chip-select cycle
    logic       sr1 = 1'b0;
    logic [2:0] sr3 = '0;
    always @(posedge clk) begin
        sr1 <= rom_cs;
        sr3 <= {sr3[1:0], b_rom_cs};
    end
    assign rom_data   = sr1 ? mem(rom_addr) : 32'hDEADBEEF;
    assign b_rom_data = sr3[2] ? mem(b_rom_addr) : 32'hDEADBEEF;

    typedef struct {
        bit          d;
        logic [31:0] data;
        bit          err;
        int          due;
    } exp_t;
    exp_t q[$];

    task automatic test_reset;
        @(negedge clk); #1;
        n_cmp++;
        if ({i_gnt, d_gnt, i_rvalid, d_rvalid, i_err, d_err, rom_cs, i_rdata, d_rdata, rom_addr} !== '0) begin
            n_bad++;
            $display("FAIL reset_outputs: got gnt=%b%b rv=%b%b cs=%b addr=%h, want all zero", i_gnt, d_gnt, i_rvalid, d_rvalid, rom_cs, rom_addr);
        end
        reset = 1'b0;
        repeat (2) @(negedge clk);
        n_cmp++;
        if ({i_gnt, d_gnt, i_rvalid, d_rvalid, rom_cs, b_rom_cs, b_i_rvalid} !== '0) begin
            n_bad++;
            $display("FAIL idle_after_reset: got gnt=%b%b rv=%b%b cs=%b/%b, want zero", i_gnt, d_gnt, i_rvalid, d_rvalid, rom_cs, b_rom_cs);
        end
    endtask

    task automatic test_fetch;
        exp_t e;
        int   t, k;
        @(negedge clk); i_addr = 32'h16C; i_req = 1'b1; #1;
        t = cyc;
        n_cmp++;
        if ({i_gnt, d_gnt} !== 2'b10) begin
            n_bad++; $display("FAIL fetch_gnt: got i/d=%b%b, want 10", i_gnt, d_gnt);
        end
        q.push_back('{d: 1'b0, data: 32'h00000093, err: 1'b0, due: t + 3});
        @(posedge clk); #1 i_req = 1'b0;
        @(negedge clk);
        n_cmp++;
        if ({rom_cs, rom_addr} !== {1'b1, 32'h16C}) begin
            n_bad++; $display("FAIL fetch_cs: got cs=%b addr=%h, want 1 0000016c", rom_cs, rom_addr);
        end
        @(negedge clk);
        n_cmp++;
        if ({rom_cs, rom_addr} !== {1'b0, 32'h16C}) begin
            n_bad++; $display("FAIL fetch_cs_pulse: got cs=%b addr=%h, want 0 0000016c", rom_cs, rom_addr);
        end
        k = 0;
        while (!(i_rvalid || d_rvalid) && k < 20) begin @(negedge clk); k++; end
        e = q.pop_front();
        n_cmp++;
        if ({d_rvalid, i_rvalid} !== {e.d, ~e.d} || cyc != e.due || (e.d ? {d_rdata, d_err} : {i_rdata, i_err}) !== {e.data, e.err}) begin
            n_bad++;
            $display("FAIL fetch_rsp: got rv d/i=%b%b cyc=%0d i=%h/%b d=%h/%b, want d=%b cyc=%0d data=%h err=%b", d_rvalid, i_rvalid, cyc, i_rdata, i_err, d_rdata, d_err, e.d, e.due, e.data, e.err);
        end
        @(negedge clk);
        n_cmp++;
        if ({i_rvalid, i_rdata} !== {1'b0, 32'h00000093}) begin
            n_bad++; $display("FAIL fetch_hold: got rv=%b data=%h, want 0 00000093", i_rvalid, i_rdata);
        end
    endtask

    task automatic test_contention;
        exp_t e;
        int   t, k;
        @(negedge clk); i_addr = 32'h170; d_addr = 32'h18C; i_req = 1'b1; d_req = 1'b1; #1;
        t = cyc;
        n_cmp++;
        if ({i_gnt, d_gnt} !== 2'b01) begin
            n_bad++; $display("FAIL contend_gnt: got i/d=%b%b, want 01", i_gnt, d_gnt);
        end
        q.push_back('{d: 1'b1, data: 32'h0000A703, err: 1'b0, due: t + 3});
        @(posedge clk); #1 d_req = 1'b0;
        k = 0;
        while (!(i_rvalid || d_rvalid) && k < 20) begin @(negedge clk); k++; end
        e = q.pop_front();
        n_cmp++;
        if ({d_rvalid, i_rvalid} !== {e.d, ~e.d} || cyc != e.due || (e.d ? {d_rdata, d_err} : {i_rdata, i_err}) !== {e.data, e.err}) begin
            n_bad++;
            $display("FAIL contend_d_rsp: got rv d/i=%b%b cyc=%0d i=%h/%b d=%h/%b, want d=%b cyc=%0d data=%h err=%b", d_rvalid, i_rvalid, cyc, i_rdata, i_err, d_rdata, d_err, e.d, e.due, e.data, e.err);
        end
        k = 0;
        do begin @(negedge clk); #1; k++; end while (!i_gnt && k < 20);
        n_cmp++;
        if (i_gnt !== 1'b1 || cyc != t + 4) begin
            n_bad++; $display("FAIL contend_i_gnt: got gnt=%b at cyc %0d, want 1 at %0d", i_gnt, cyc, t + 4);
        end
        q.push_back('{d: 1'b0, data: 32'h00000113, err: 1'b0, due: cyc + 3});
        @(posedge clk); #1 i_req = 1'b0;
        k = 0;
        while (!(i_rvalid || d_rvalid) && k < 20) begin @(negedge clk); k++; end
        e = q.pop_front();
        n_cmp++;
        if ({d_rvalid, i_rvalid} !== {e.d, ~e.d} || cyc != e.due || (e.d ? {d_rdata, d_err} : {i_rdata, i_err}) !== {e.data, e.err}) begin
            n_bad++;
            $display("FAIL contend_i_rsp: got rv d/i=%b%b cyc=%0d i=%h/%b d=%h/%b, want d=%b cyc=%0d data=%h err=%b", d_rvalid, i_rvalid, cyc, i_rdata, i_err, d_rdata, d_err, e.d, e.due, e.data, e.err);
        end
    endtask

    task automatic test_misaligned;
        exp_t e;
        int   t, k;
        bit   cs_seen;
        @(negedge clk); d_addr = 32'h172; d_req = 1'b1; #1;
        t = cyc;
        n_cmp++;
        if ({i_gnt, d_gnt} !== 2'b01) begin
            n_bad++; $display("FAIL mis_gnt: got i/d=%b%b, want 01", i_gnt, d_gnt);
        end
        q.push_back('{d: 1'b1, data: 32'h0, err: 1'b1, due: t + 1});
        @(posedge clk); #1 d_req = 1'b0;
        cs_seen = rom_cs;
        k = 0;
        while (!(i_rvalid || d_rvalid) && k < 20) begin @(negedge clk); k++; end
        e = q.pop_front();
        n_cmp++;
        if ({d_rvalid, i_rvalid} !== {e.d, ~e.d} || cyc != e.due || (e.d ? {d_rdata, d_err} : {i_rdata, i_err}) !== {e.data, e.err}) begin
            n_bad++;
            $display("FAIL mis_rsp: got rv d/i=%b%b cyc=%0d i=%h/%b d=%h/%b, want d=%b cyc=%0d data=%h err=%b", d_rvalid, i_rvalid, cyc, i_rdata, i_err, d_rdata, d_err, e.d, e.due, e.data, e.err);
        end
        repeat (4) begin @(negedge clk); cs_seen |= rom_cs; end
        n_cmp++;
        if (cs_seen !== 1'b0 || rom_addr !== 32'h170 || i_rdata !== 32'h00000113) begin
            n_bad++; $display("FAIL mis_no_cs: got cs_seen=%b rom_addr=%h i_rdata=%h, want 0 00000170 00000113", cs_seen, rom_addr, i_rdata);
        end
    endtask

    task automatic test_starve;
        exp_t e;
        int   t, k;
        bit   w;
        @(negedge clk); d_addr = 32'h100; i_addr = 32'h104; d_req = 1'b1; i_req = 1'b1;
        for (int g = 0; g < 10; g++) begin
            #1;
            k = 0;
            while (!(i_gnt || d_gnt) && k < 20) begin @(negedge clk); #1; k++; end
            w = (g % 5) != 4;
            t = cyc;
            n_cmp++;
            if ({i_gnt, d_gnt} !== {~w, w}) begin
                n_bad++; $display("FAIL starve_gnt%0d: got i/d=%b%b, want %b%b", g, i_gnt, d_gnt, ~w, w);
            end
            q.push_back('{d: w, data: mem(w ? 32'h100 : 32'h104), err: 1'b0, due: t + 3});
            @(posedge clk); #1;
            k = 0;
            while (!(i_rvalid || d_rvalid) && k < 20) begin @(negedge clk); k++; end
            e = q.pop_front();
            n_cmp++;
            if ({d_rvalid, i_rvalid} !== {e.d, ~e.d} || cyc != e.due || (e.d ? {d_rdata, d_err} : {i_rdata, i_err}) !== {e.data, e.err}) begin
                n_bad++;
                $display("FAIL starve_rsp%0d: got rv d/i=%b%b cyc=%0d i=%h/%b d=%h/%b, want d=%b cyc=%0d data=%h err=%b", g, d_rvalid, i_rvalid, cyc, i_rdata, i_err, d_rdata, d_err, e.d, e.due, e.data, e.err);
            end
            @(negedge clk);
        end
        d_req = 1'b0; i_req = 1'b0;
    endtask

    task automatic test_reset_wait;
        exp_t e;
        int   t, k;
        @(negedge clk); i_addr = 32'h198; i_req = 1'b1; #1;
        n_cmp++;
        if (i_gnt !== 1'b1) begin
            n_bad++; $display("FAIL rstw_gnt: got %b, want 1", i_gnt);
        end
        @(posedge clk); #1 i_req = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b1; #1;
        n_cmp++;
        if ({i_gnt, d_gnt, i_rvalid, d_rvalid, i_err, d_err, rom_cs, i_rdata, d_rdata, rom_addr} !== '0) begin
            n_bad++; $display("FAIL rstw_zero: got rv=%b%b i_rdata=%h d_rdata=%h rom_addr=%h, want all zero", i_rvalid, d_rvalid, i_rdata, d_rdata, rom_addr);
        end
        repeat (2) @(negedge clk);
        reset = 1'b0;
        k = 0;
        repeat (6) begin @(negedge clk); if (i_rvalid || d_rvalid || rom_cs) k++; end
        n_cmp++;
        if (k != 0) begin
            n_bad++; $display("FAIL rstw_dropped: got %0d active cycles after reset, want 0", k);
        end
        i_req = 1'b1; #1;
        t = cyc;
        n_cmp++;
        if (i_gnt !== 1'b1) begin
            n_bad++; $display("FAIL rstw_regnt: got %b, want 1", i_gnt);
        end
        q.push_back('{d: 1'b0, data: 32'h2A761663, err: 1'b0, due: t + 3});
        @(posedge clk); #1 i_req = 1'b0;
        k = 0;
        while (!(i_rvalid || d_rvalid) && k < 20) begin @(negedge clk); k++; end
        e = q.pop_front();
        n_cmp++;
        if ({d_rvalid, i_rvalid} !== {e.d, ~e.d} || cyc != e.due || (e.d ? {d_rdata, d_err} : {i_rdata, i_err}) !== {e.data, e.err}) begin
            n_bad++;
            $display("FAIL rstw_rsp: got rv d/i=%b%b cyc=%0d i=%h/%b d=%h/%b, want d=%b cyc=%0d data=%h err=%b", d_rvalid, i_rvalid, cyc, i_rdata, i_err, d_rdata, d_err, e.d, e.due, e.data, e.err);
        end
    endtask

    task automatic test_lat3;
        exp_t e;
        int   t, k;
        @(negedge clk); b_i_addr = 32'h17C; b_i_req = 1'b1; #1;
        t = cyc;
        n_cmp++;
        if ({b_i_gnt, b_d_gnt} !== 2'b10) begin
            n_bad++; $display("FAIL lat3_gnt: got i/d=%b%b, want 10", b_i_gnt, b_d_gnt);
        end
        q.push_back('{d: 1'b0, data: 32'h00FF07B7, err: 1'b0, due: t + 5});
        @(posedge clk); #1 b_i_req = 1'b0;
        @(negedge clk);
        n_cmp++;
        if ({b_rom_cs, b_rom_addr} !== {1'b1, 32'h17C}) begin
            n_bad++; $display("FAIL lat3_cs: got cs=%b addr=%h, want 1 0000017c", b_rom_cs, b_rom_addr);
        end
        k = 0;
        while (!(b_i_rvalid || b_d_rvalid) && k < 20) begin @(negedge clk); k++; end
        e = q.pop_front();
        n_cmp++;
        if ({b_d_rvalid, b_i_rvalid} !== {e.d, ~e.d} || cyc != e.due || {b_i_rdata, b_i_err} !== {e.data, e.err}) begin
            n_bad++;
            $display("FAIL lat3_rsp: got rv d/i=%b%b cyc=%0d data=%h err=%b, want cyc=%0d data=%h err=%b", b_d_rvalid, b_i_rvalid, cyc, b_i_rdata, b_i_err, e.due, e.data, e.err);
        end
    endtask

    initial begin
        test_reset;
        test_fetch;
        test_contention;
        test_misaligned;
        test_starve;
        test_reset_wait;
        test_lat3;
        repeat (2) @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
